// File: rtl/bcd_mod_counter.sv
// Parametrised packed-BCD modulo counter: up/down count, range-checked synchronous
// load, combinational terminal-count output for chaining stages via co -> en.
module bcd_mod_counter #(
  parameter int unsigned NDIG    = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] count,
  output logic              co,
  output logic              load_err
);

  localparam int unsigned W = 4 * NDIG;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] b;
    int unsigned  x;
    b = '0;
    x = v;
    for (int unsigned i = 0; i < NDIG; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  localparam logic [W-1:0] MAXV = to_bcd(MODULUS - 1);

  generate
    if ((MODULUS < 2) || (MODULUS > pow10(NDIG))) begin : g_bad_modulus
      $error("bcd_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 10**NDIG");
    end
  endgenerate

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] next_count;
  logic         next_err;
  logic         digits_ok;
  logic         load_ok;
  logic         carry;
  logic         borrow;
  logic         count_ok;

  // With every digit <= 9, packed BCD orders like plain binary, so the range
  // check is a direct unsigned compare against the BCD image of MODULUS-1.
  always_comb begin
    digits_ok = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (load_val <= MAXV);
  end

  always_comb begin
    inc_val = count;
    carry   = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (count == MAXV) inc_val = '0;
  end

  always_comb begin
    dec_val = count;
    borrow  = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
    if (count == '0) dec_val = MAXV;
  end

  always_comb begin
    next_count = count;
    next_err   = 1'b0;
    if (load) begin
      if (load_ok) next_count = load_val;
      else         next_err   = 1'b1;
    end else if (en) begin
      next_count = up ? inc_val : dec_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      load_err <= 1'b0;
    end else begin
      count    <= next_count;
      load_err <= next_err;
    end
  end

  assign co = rst & en & ~load & (up ? (count == MAXV) : (count == '0));

  always_comb begin
    count_ok = (count <= MAXV);
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (count[4*i +: 4] > 4'd9) count_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (count_ok);
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: mod-60 core, sec/min/hour cascade and a
// 3-digit mod-1000 instance.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // main mod-60 instance
  logic       rst, en, up, load;
  logic [7:0] load_val, count;
  logic       co, load_err;

  bcd_mod_counter #(.NDIG(2), .MODULUS(60)) u_main (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .co(co), .load_err(load_err)
  );

  // cascade sec -> min -> hour
  logic       crst, cen, cload;
  logic [7:0] s_lv, m_lv, h_lv, s_cnt, m_cnt, h_cnt;
  logic       s_co, m_co, h_co, s_err, m_err, h_err;

  bcd_mod_counter #(.NDIG(2), .MODULUS(60)) u_sec (
    .clk(clk), .rst(crst), .en(cen), .up(1'b1), .load(cload), .load_val(s_lv),
    .count(s_cnt), .co(s_co), .load_err(s_err)
  );
  bcd_mod_counter #(.NDIG(2), .MODULUS(60)) u_min (
    .clk(clk), .rst(crst), .en(s_co), .up(1'b1), .load(cload), .load_val(m_lv),
    .count(m_cnt), .co(m_co), .load_err(m_err)
  );
  bcd_mod_counter #(.NDIG(2), .MODULUS(24)) u_hour (
    .clk(clk), .rst(crst), .en(m_co), .up(1'b1), .load(cload), .load_val(h_lv),
    .count(h_cnt), .co(h_co), .load_err(h_err)
  );

  // 3-digit mod-1000 instance
  logic        r3, en3, up3, l3, co3, err3;
  logic [11:0] lv3, cnt3;

  bcd_mod_counter #(.NDIG(3), .MODULUS(1000)) u_d3 (
    .clk(clk), .rst(r3), .en(en3), .up(up3), .load(l3), .load_val(lv3),
    .count(cnt3), .co(co3), .load_err(err3)
  );

  typedef struct {
    logic       r, e, u, l;
    logic [7:0] lv;
    logic       xco;
    logic [7:0] xcnt;
    logic       xerr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // one cycle on the main instance: co checked before the edge, count/load_err after it
  task automatic cyc(input string nm, input logic r, e, u, l, input logic [7:0] lv,
                     input logic xco, input logic [7:0] xcnt, input logic xerr);
    @(negedge clk);
    rst = r; en = e; up = u; load = l; load_val = lv;
    #1 chk({nm, "_co"}, 32'(co), 32'(xco));
    @(posedge clk);
    #1;
    chk({nm, "_count"}, 32'(count), 32'(xcnt));
    chk({nm, "_err"}, 32'(load_err), 32'(xerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int pulses;
  logic [23:0] exp_hms[4];

  initial begin
    //            r     e     u     l     lv     xco   xcnt   xerr
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h45, 1'b0, 8'h45, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h60, 1'b0, 8'h45, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h45, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h3A, 1'b0, 8'h45, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h59, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h59, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 8'h59, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h59, 1'b0};

    exp_hms[0] = 24'h235958;
    exp_hms[1] = 24'h235959;
    exp_hms[2] = 24'h000000;
    exp_hms[3] = 24'h000001;

    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
    crst = 1'b0; cen = 1'b0; cload = 1'b0; s_lv = '0; m_lv = '0; h_lv = '0;
    r3 = 1'b0; en3 = 1'b0; up3 = 1'b1; l3 = 1'b0; lv3 = '0;

    // reset
    @(negedge clk);
    #1 chk("rst_co", 32'(co), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);

    // full upward cycle 00..59 -> 00
    @(negedge clk);
    rst = 1'b1; crst = 1'b1; r3 = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      chk("up_count", 32'(count), 32'(bcd2(i)));
      chk("up_co", 32'(co), 32'(i == 59));
      @(negedge clk);
    end
    #1 chk("up_wrap", 32'(count), 32'h00);

    // downward: 00 -> 59, then borrow 50 -> 49
    up = 1'b0;
    #1 chk("dn_co_at_00", 32'(co), 32'd1);
    @(negedge clk);
    for (int i = 59; i >= 49; i--) begin
      #1;
      chk("dn_count", 32'(count), 32'(bcd2(i)));
      chk("dn_co", 32'(co), 32'd0);
      if (i != 49) @(negedge clk);
    end
    en = 1'b0;

    // table: load acceptance/rejection, priorities, wrap boundaries
    for (int k = 0; k < 12; k++) begin
      cyc($sformatf("vec%0d", k), vecs[k].r, vecs[k].e, vecs[k].u, vecs[k].l,
          vecs[k].lv, vecs[k].xco, vecs[k].xcnt, vecs[k].xerr);
    end

    // reset in the middle of counting, with a pending load and a set load_err
    cyc("mid_load35", 1'b1, 1'b0, 1'b1, 1'b1, 8'h35, 1'b0, 8'h35, 1'b0);
    cyc("mid_36",     1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h36, 1'b0);
    cyc("mid_37",     1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h37, 1'b0);
    cyc("mid_rej",    1'b1, 1'b1, 1'b1, 1'b1, 8'h7A, 1'b0, 8'h37, 1'b1);
    cyc("mid_rst",    1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
    cyc("resume_01",  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0);
    cyc("resume_02",  1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0);
    @(negedge clk);
    en = 1'b0;

    // cascade from 23:59:58
    cload = 1'b1; h_lv = 8'h23; m_lv = 8'h59; s_lv = 8'h58;
    @(posedge clk);
    #1 chk("cas_load", 32'({h_cnt, m_cnt, s_cnt}), 32'h235958);
    @(negedge clk);
    cload = 1'b0; cen = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cas_hms%0d", k), 32'({h_cnt, m_cnt, s_cnt}), 32'(exp_hms[k]));
      if (h_co) pulses++;
      @(negedge clk);
    end
    cen = 1'b0;
    chk("cas_hour_co_pulses", 32'(pulses), 32'd1);

    // 3-digit instance: 998 -> 999 -> 000 and 100 -> 099
    l3 = 1'b1; lv3 = 12'h998;
    @(posedge clk);
    #1 chk("d3_load998", 32'(cnt3), 32'h998);
    @(negedge clk);
    l3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
    #1 chk("d3_co_998", 32'(co3), 32'd0);
    @(posedge clk);
    #1 chk("d3_999", 32'(cnt3), 32'h999);
    @(negedge clk);
    #1 chk("d3_co_999", 32'(co3), 32'd1);
    @(posedge clk);
    #1 chk("d3_wrap", 32'(cnt3), 32'h000);
    @(negedge clk);
    en3 = 1'b0; l3 = 1'b1; lv3 = 12'h100;
    @(posedge clk);
    #1 chk("d3_load100", 32'(cnt3), 32'h100);
    @(negedge clk);
    l3 = 1'b0; en3 = 1'b1; up3 = 1'b0;
    #1 chk("d3_co_100", 32'(co3), 32'd0);
    @(posedge clk);
    #1 chk("d3_099", 32'(cnt3), 32'h099);
    @(negedge clk);
    en3 = 1'b0; l3 = 1'b1; lv3 = 12'h9A9;
    @(posedge clk);
    #1;
    chk("d3_rej_count", 32'(cnt3), 32'h099);
    chk("d3_rej_err", 32'(err3), 32'd1);
    @(negedge clk);
    l3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
